pipe_mem_stage: RTL

//  MEM stage of the 5-stage pipeline. Sits downstream of the EX stage, after the E/M register.

---
 rtl/pipe_mem_stage_pkg.sv | 22 ++
 rtl/pipe_mw_reg.sv | 30 +++
 rtl/pipe_mem_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipe_mem_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM states, word-offset mask and the M/W payload.
package pipe_mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] WORD_MASK = 2'b11;

    typedef struct packed {
        logic        wwreg;
        logic        wm2reg;
        logic [4:0]  wrn;
        logic [31:0] walu;
        logic [31:0] wmo;
        logic        werr;
    } mw_t;

    localparam mw_t MW_BUBBLE = '0;

endpackage

// File: rtl/pipe_mw_reg.sv
// M/W pipeline register: loads either the MEM-stage result or a bubble carrying an error flag.
module pipe_mw_reg
    import pipe_mem_stage_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic load_bubble,
    input  logic bubble_err,
    input  mw_t  d,
    output mw_t  q
);

    mw_t bubble;

    always_comb begin
        bubble      = MW_BUBBLE;
        bubble.werr = bubble_err;
    end

    // NOTE: reset is sampled on the clock edge only, and all state uses non-blocking assignment.
    always_ff @(posedge clock) begin
        if (!resetn)
            q <= MW_BUBBLE;
        else if (load_bubble)
            q <= bubble;
        else
            q <= d;
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: word load/store over a req/ack handshake, stalls upstream while waiting,
// aborts after TIMEOUT wait cycles, and feeds the M/W register.
module pipe_mem_stage
    import pipe_mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mvalid,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [4:0]  mrn,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mstall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wrn,
    output logic [31:0] walu,
    output logic [31:0] wmo,
    output logic        werr
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mem_op, aligned, acc, bad, in_wait, at_limit;
    logic             stall, abort;
    mw_t              w_d, w_q;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        mem_op   = mvalid & (mm2reg | mwmem);
        aligned  = (malu[1:0] & WORD_MASK) == 2'b00;
        acc      = mem_op & aligned;
        bad      = mem_op & ~aligned;
        in_wait  = (state == ST_WAIT);
        at_limit = in_wait & (cnt == CNT_LIMIT);
        stall    = in_wait ? (~mem_ack & ~at_limit) : (acc & ~mem_ack);
        abort    = in_wait & ~mem_ack & at_limit;

        // Reset withdraws the request and the stall in the same cycle.
        mem_req   = resetn & (in_wait | acc);
        mstall    = resetn & stall;
        mem_we    = mwmem;
        mem_addr  = {malu[31:2], 2'b00};
        mem_wdata = mb;

        w_d        = MW_BUBBLE;
        w_d.wwreg  = mwreg & mvalid & ~bad;
        w_d.wm2reg = mm2reg;
        w_d.wrn    = mrn;
        w_d.walu   = malu;
        w_d.wmo    = (acc & mm2reg & mem_ack) ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc && !mem_ack) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // An ack on the timeout cycle still completes the access.
                    if (mem_ack || at_limit) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    pipe_mw_reg u_mw_reg (
        .clock       (clock),
        .resetn      (resetn),
        .load_bubble (stall | bad | abort),
        .bubble_err  (bad | abort),
        .d           (w_d),
        .q           (w_q)
    );

    assign wwreg  = w_q.wwreg;
    assign wm2reg = w_q.wm2reg;
    assign wrn    = w_q.wrn;
    assign walu   = w_q.walu;
    assign wmo    = w_q.wmo;
    assign werr   = w_q.werr;

endmodule
